// File: rtl/relu_row_unpacker.sv
// Reassembles a stream of 128-bit, 4-lane beats into full PU rows.
// It tracks the row position within a frame, checks in_last framing and pulses frame_done.
module relu_row_unpacker #(
  parameter  int NUM_PUS        = 64,
  parameter  int BIAS_WIDTH     = 32,
  parameter  int ROWS_PER_FRAME = 25,
  localparam int NUM_GROUPS     = (NUM_PUS + 3) / 4,
  localparam int ROW_W          = NUM_PUS * BIAS_WIDTH,
  localparam int IDX_W          = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic             in_last,
  output logic             row_valid,
  input  logic             row_ready,
  output logic [ROW_W-1:0] row_data,
  output logic [IDX_W-1:0] row_index,
  output logic             frame_done,
  output logic             framing_error
);
  localparam int GRP_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  typedef logic [NUM_PUS-1:0][BIAS_WIDTH-1:0] row_t;

  row_t             r_asm, r_out, w_asm_nxt;
  logic [GRP_W-1:0] r_grp;
  logic [IDX_W-1:0] r_row_cnt, r_asm_idx, r_out_idx, w_cnt_inc;
  logic             r_asm_full, r_in_rdy, r_out_vld, r_fd, r_err;
  logic             w_acc, w_out_fire, w_out_free, w_last_grp, w_last_exp;
  logic             w_row_done, w_asm_full_nxt;

  assign w_acc      = in_valid && r_in_rdy;
  assign w_out_fire = r_out_vld && row_ready;
  assign w_out_free = !r_out_vld || w_out_fire;
  assign w_last_grp = (r_grp == GRP_W'(NUM_GROUPS - 1));
  assign w_last_exp = w_last_grp && (r_row_cnt == IDX_W'(ROWS_PER_FRAME - 1));
  assign w_row_done = w_last_grp || in_last;
  assign w_cnt_inc  = (r_row_cnt == IDX_W'(ROWS_PER_FRAME - 1)) ? '0 : r_row_cnt + 1'b1;

  // A finished row parks in the assembly register only while the output register is busy.
  assign w_asm_full_nxt = r_asm_full ? !w_out_fire : (w_acc && w_row_done && !w_out_free);

  // Each PU has a fixed lane slot within its group; lanes past NUM_PUS have no PU and are dropped.
  always_comb begin
    w_asm_nxt = r_asm;
    for (int p = 0; p < NUM_PUS; p++) begin
      if (r_grp == GRP_W'(p / 4))
        w_asm_nxt[p] = in_data[(p % 4) * BIAS_WIDTH +: BIAS_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_asm      <= '0;
      r_out      <= '0;
      r_grp      <= '0;
      r_row_cnt  <= '0;
      r_asm_idx  <= '0;
      r_out_idx  <= '0;
      r_asm_full <= 1'b0;
      r_in_rdy   <= 1'b0;
      r_out_vld  <= 1'b0;
      r_fd       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_asm_full <= w_asm_full_nxt;
      r_in_rdy   <= !w_asm_full_nxt;
      r_fd       <= w_out_fire && (r_out_idx == IDX_W'(ROWS_PER_FRAME - 1));
      if (w_out_fire)
        r_out_vld <= 1'b0;
      if (r_asm_full) begin
        if (w_out_fire) begin
          r_out     <= r_asm;
          r_out_idx <= r_asm_idx;
          r_out_vld <= 1'b1;
          r_asm     <= '0;
        end
      end else if (w_acc) begin
        if (in_last != w_last_exp)
          r_err <= 1'b1;
        if (w_row_done) begin
          r_grp     <= '0;
          // Any in_last, expected or not, realigns the next row to the start of a frame.
          r_row_cnt <= in_last ? '0 : w_cnt_inc;
          if (w_out_free) begin
            r_out     <= w_asm_nxt;
            r_out_idx <= r_row_cnt;
            r_out_vld <= 1'b1;
            r_asm     <= '0;
          end else begin
            r_asm     <= w_asm_nxt;
            r_asm_idx <= r_row_cnt;
          end
        end else begin
          r_asm <= w_asm_nxt;
          r_grp <= r_grp + 1'b1;
        end
      end
    end
  end

  assign in_ready      = r_in_rdy;
  assign row_valid     = r_out_vld;
  assign row_data      = r_out;
  assign row_index     = r_out_idx;
  assign frame_done    = r_fd;
  assign framing_error = r_err;
endmodule

// File: tb/tb_relu_row_unpacker.sv
// Directed bench for relu_row_unpacker: a table of per-cycle vectors on a 6-PU instance,
// plus hand-written sequences on the default 64-PU instance.
module tb_relu_row_unpacker;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_last = 1'b0, row_ready = 1'b1;
  logic [127:0]  in_data = '0;
  logic          in_ready, row_valid, frame_done, framing_error;
  logic [2047:0] row_data;
  logic [4:0]    row_index;

  logic          s_in_valid = 1'b0, s_in_last = 1'b0, s_row_ready = 1'b1;
  logic [127:0]  s_in_data = '0;
  logic          s_in_ready, s_row_valid, s_frame_done, s_framing_error;
  logic [191:0]  s_row_data;
  logic [4:0]    s_row_index;

  int n_chk = 0, n_fail = 0, fd_cnt = 0;

  always #5 clk = ~clk;

  relu_row_unpacker u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_index(row_index), .frame_done(frame_done), .framing_error(framing_error));

  relu_row_unpacker #(.NUM_PUS(6)) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .in_last(s_in_last), .row_valid(s_row_valid), .row_ready(s_row_ready),
    .row_data(s_row_data), .row_index(s_row_index), .frame_done(s_frame_done),
    .framing_error(s_framing_error));

  typedef struct {
    logic         vld;
    logic [127:0] d;
    logic         last;
    logic         rr;
    logic         e_rv;
    logic         e_rdy;
    logic [191:0] e_data;
    logic [4:0]   e_idx;
    logic         e_err;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [127:0] pk4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [191:0] pk6(input logic [31:0] a0, a1, a2, a3, a4, a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  // Lane value for PU p of a row tagged 'tag'; only the first npu PUs carry data.
  function automatic logic [2047:0] mk_row(input int tag, input int npu);
    logic [2047:0] r;
    r = '0;
    for (int p = 0; p < 64; p++)
      if (p < npu) r[p*32 +: 32] = 32'(tag * 65536 + p);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_row(input string nm, input logic [2047:0] exp);
    int bad;
    bad = -1;
    n_chk++;
    for (int p = 63; p >= 0; p--)
      if (row_data[p*32 +: 32] !== exp[p*32 +: 32]) bad = p;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: PU %0d got %0h want %0h", nm, bad, row_data[bad*32 +: 32],
               exp[bad*32 +: 32]);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Sends groups g0..g1 of a tagged row back to back; in_last on group lastg (-1: none).
  task automatic send_beats(input int tag, input int g0, input int g1, input int lastg);
    for (int g = g0; g <= g1; g++) begin
      int w;
      w = 0;
      while (!in_ready && w < 200) begin
        tick();
        w++;
      end
      if (!in_ready) begin
        n_chk++;
        n_fail++;
        $display("FAIL in_ready_timeout: got 0 want 1 (tag %0d group %0d)", tag, g);
      end
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = 32'(tag * 65536 + 4 * g + k);
      in_last = (g == lastg);
      tick();
      fd_cnt += int'(frame_done);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, pk4(0, 1, 2, 3), 1'b0, 1'b1, 1'b0, 1'b1, 192'd0, 5'd0, 1'b0};
    tbl[1] = '{1'b1, pk4(4, 5, 32'hBEEF_0000, 32'hDEAD_0000), 1'b0, 1'b1, 1'b1, 1'b1,
               pk6(0, 1, 2, 3, 4, 5), 5'd0, 1'b0};
    tbl[2] = '{1'b1, pk4(10, 11, 12, 13), 1'b0, 1'b0, 1'b1, 1'b1,
               pk6(0, 1, 2, 3, 4, 5), 5'd0, 1'b0};
    tbl[3] = '{1'b1, pk4(14, 15, 16, 17), 1'b0, 1'b0, 1'b1, 1'b0,
               pk6(0, 1, 2, 3, 4, 5), 5'd0, 1'b0};
    tbl[4] = '{1'b1, pk4(90, 91, 92, 93), 1'b0, 1'b1, 1'b1, 1'b1,
               pk6(10, 11, 12, 13, 14, 15), 5'd1, 1'b0};
    tbl[5] = '{1'b0, 128'd0, 1'b0, 1'b1, 1'b0, 1'b1, 192'd0, 5'd0, 1'b0};
    tbl[6] = '{1'b1, pk4(20, 21, 22, 23), 1'b1, 1'b1, 1'b1, 1'b1,
               pk6(20, 21, 22, 23, 0, 0), 5'd2, 1'b1};
    tbl[7] = '{1'b1, pk4(30, 31, 32, 33), 1'b0, 1'b1, 1'b0, 1'b1, 192'd0, 5'd0, 1'b1};
    tbl[8] = '{1'b1, pk4(34, 35, 36, 37), 1'b0, 1'b1, 1'b1, 1'b1,
               pk6(30, 31, 32, 33, 34, 35), 5'd0, 1'b1};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 192'(in_ready), 0);
    chk("rst_row_valid", 192'(row_valid), 0);
    chk("rst_row_data", 192'(row_data != '0), 0);
    chk("rst_row_index", 192'(row_index), 0);
    chk("rst_frame_done", 192'(frame_done), 0);
    chk("rst_err", 192'(framing_error), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 192'(in_ready), 1);
    chk("post_rst_in_ready6", 192'(s_in_ready), 1);

    // 6-PU instance: partial final group, backpressure and early in_last
    for (int i = 0; i < 9; i++) begin
      s_in_valid  = tbl[i].vld;
      s_in_data   = tbl[i].d;
      s_in_last   = tbl[i].last;
      s_row_ready = tbl[i].rr;
      tick();
      chk($sformatf("t6_rv_%0d", i), 192'(s_row_valid), 192'(tbl[i].e_rv));
      chk($sformatf("t6_rdy_%0d", i), 192'(s_in_ready), 192'(tbl[i].e_rdy));
      chk($sformatf("t6_err_%0d", i), 192'(s_framing_error), 192'(tbl[i].e_err));
      if (tbl[i].e_rv) begin
        chk($sformatf("t6_data_%0d", i), s_row_data, tbl[i].e_data);
        chk($sformatf("t6_idx_%0d", i), 192'(s_row_index), 192'(tbl[i].e_idx));
      end
    end
    s_in_valid = 1'b0;
    s_in_last  = 1'b0;

    // Lane value equals PU index; row appears one cycle after the 16th beat
    row_ready = 1'b1;
    send_beats(0, 0, 14, -1);
    chk("t1_not_early", 192'(row_valid), 0);
    send_beats(0, 15, 15, -1);
    chk("t1_valid", 192'(row_valid), 1);
    chk_row("t1_data", mk_row(0, 64));
    chk("t1_idx", 192'(row_index), 0);
    tick();
    chk("t1_drained", 192'(row_valid), 0);

    // Backpressure: second row parks in the assembly register
    row_ready = 1'b0;
    send_beats(1, 0, 15, -1);
    send_beats(2, 0, 15, -1);
    chk("t3_in_ready_low", 192'(in_ready), 0);
    chk("t3_valid", 192'(row_valid), 1);
    chk("t3_idx_a", 192'(row_index), 1);
    in_valid = 1'b1;
    in_data  = {4{32'hFFFF_FFFF}};
    for (int i = 0; i < 3; i++) tick();
    chk("t3_hold_rdy", 192'(in_ready), 0);
    chk("t3_hold_idx", 192'(row_index), 1);
    chk_row("t3_hold_data", mk_row(1, 64));
    in_valid  = 1'b0;
    row_ready = 1'b1;
    tick();
    chk("t3_b_valid", 192'(row_valid), 1);
    chk("t3_b_idx", 192'(row_index), 2);
    chk_row("t3_b_data", mk_row(2, 64));
    chk("t3_rdy_back", 192'(in_ready), 1);
    tick();
    chk("t3_drained", 192'(row_valid), 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Full frame with in_last on the final beat of row 24
    fd_cnt = 0;
    for (int r = 0; r < 25; r++) begin
      send_beats(100 + r, 0, 15, (r == 24) ? 15 : -1);
      chk($sformatf("t4_valid_%0d", r), 192'(row_valid), 1);
      chk($sformatf("t4_idx_%0d", r), 192'(row_index), 192'(r));
      chk_row($sformatf("t4_data_%0d", r), mk_row(100 + r, 64));
    end
    chk("t4_no_early_fd", 192'(fd_cnt), 0);
    tick();
    chk("t4_frame_done", 192'(frame_done), 1);
    tick();
    chk("t4_fd_one_cycle", 192'(frame_done), 0);
    chk("t4_no_err", 192'(framing_error), 0);
    send_beats(200, 0, 15, -1);
    chk("t4_wrap_idx", 192'(row_index), 0);
    send_beats(201, 0, 15, -1);
    chk("t4_idx1", 192'(row_index), 1);

    // Early in_last on the third beat of row 2
    send_beats(202, 0, 2, 2);
    chk("t5_valid", 192'(row_valid), 1);
    chk("t5_idx", 192'(row_index), 2);
    chk_row("t5_data", mk_row(202, 12));
    chk("t5_err", 192'(framing_error), 1);
    send_beats(203, 0, 15, -1);
    chk("t5_resync_idx", 192'(row_index), 0);
    chk_row("t5_next_data", mk_row(203, 64));
    chk("t5_err_sticky", 192'(framing_error), 1);
    tick();

    // Reset mid-row discards the partial row
    send_beats(50, 0, 4, -1);
    rst = 1'b1;
    tick();
    chk("t6_rst_rdy", 192'(in_ready), 0);
    chk("t6_rst_err", 192'(framing_error), 0);
    chk("t6_rst_valid", 192'(row_valid), 0);
    rst = 1'b0;
    tick();
    chk("t6_rdy", 192'(in_ready), 1);
    send_beats(77, 0, 14, -1);
    chk("t6_no_stale", 192'(row_valid), 0);
    send_beats(77, 15, 15, -1);
    chk("t6_valid", 192'(row_valid), 1);
    chk("t6_idx", 192'(row_index), 0);
    chk_row("t6_data", mk_row(77, 64));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/relu_row_unpacker.md
Name: relu_row_unpacker

Overview:
- Reverse of the ReLU output packer. Accepts a 128-bit stream of 4-lane groups (4 x BIAS_WIDTH) and reassembles it into full-width PU rows (NUM_PUS x BIAS_WIDTH).
- Sits between the DMA/feature-map read path and the PU array input. Each reassembled row is presented with a valid/ready handshake.
- Tracks row position within a frame of ROWS_PER_FRAME rows, checks in_last framing, and pulses frame_done.

Parameters:
- NUM_PUS, 64, number of processing units (lanes) per row.
- BIAS_WIDTH, 32, width of one lane value. Must equal 32, because the 128-bit beat carries 4 lanes.
- ROWS_PER_FRAME, 25, number of rows per frame.
- Derived: NUM_GROUPS = ceil(NUM_PUS/4); ROW_W = NUM_PUS*BIAS_WIDTH; IDX_W = max(1, clog2(ROWS_PER_FRAME)).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  128  lane k = in_data[32k+:32], k = 0..3.
- in_last  in  1  marks the final beat of a frame.
- row_valid  out  1  row_data holds a complete row.
- row_ready  in  1  consumer accepts the row.
- row_data  out  ROW_W  PU p = row_data[p*BIAS_WIDTH +: BIAS_WIDTH].
- row_index  out  IDX_W  frame row number of the presented row.
- frame_done  out  1  one-cycle pulse.
- framing_error  out  1  sticky error flag.

Behaviour:
- Reset: takes effect on the clock edge where rst=1. After that edge, all outputs are 0 and all contents are discarded:
  - outputs: in_ready=0, row_valid=0, row_data=0, row_index=0, frame_done=0, framing_error=0;
  - internal: group counter=0, row counter=0, assembly and output registers cleared.
  - In the first cycle after rst deasserts, in_ready=1.
- Storage:
  - One assembly register (ROW_W wide) plus a group counter (0..NUM_GROUPS-1).
  - One output register driving row_data, row_index and row_valid.
  - Total capacity is two rows.
- Beat acceptance: a beat is accepted on an edge where in_valid && in_ready. in_ready = !asm_full, a registered flag.
- Lane mapping: lane k of group g is written to PU g*4+k. Lanes with g*4+k >= NUM_PUS are discarded, so the upper lanes of a partial final group are ignored.
- Row completion: a row completes when the beat with group counter NUM_GROUPS-1 is accepted, or on an early in_last (see below).
  - Output register free, or freed by a row handshake in the same cycle: the completed row goes straight to the output register. row_valid=1 from the next cycle, so latency is 1 cycle from the last beat's edge.
  - Otherwise: the row stays in the assembly register, asm_full=1 and in_ready=0. The row transfers on the edge where the output handshakes; asm_full clears and in_ready returns to 1 on the following cycle.
  - After transfer, the assembly register clears to 0 and the group counter resets to 0.
- Output handshake: completes on the edge where row_valid && row_ready.
  - row_data and row_index are held stable while row_valid && !row_ready.
  - Rows are emitted strictly in arrival order; no row is dropped or duplicated.
- Row counter:
  - Increments per completed row and wraps from ROWS_PER_FRAME-1 to 0.
  - Its value is latched into row_index with the row.
- frame_done: one-cycle pulse on the cycle after the handshake of a row with row_index == ROWS_PER_FRAME-1.
- Framing check: in_last is expected high only on the final beat of row ROWS_PER_FRAME-1.
  - Late or missing in_last: that beat is low when expected high. framing_error is set; counting continues and wraps normally.
  - Early in_last: in_last is high on any other beat. framing_error is set. The partial row completes immediately with unfilled PUs = 0, keeps its current row_index, and the row counter then resyncs to 0.
  - in_last on a beat that also completes a row (but not row ROWS_PER_FRAME-1) gives the same resync: error set, next row_index is 0.
  - framing_error is cleared only by rst.
- Simultaneous events: a beat acceptance and a row handshake in the same cycle are both honoured with no bubble. Full throughput is one beat per cycle when row_ready=1.
- Reset mid-row: partially assembled and pending rows are discarded; no row is emitted.
- Width: row_data is pure bit placement; no sign extension or arithmetic.

Test Plan:
1. Defaults, row_ready=1, 16 beats with lane value = PU index (beat g = {4g+3, 4g+2, 4g+1, 4g}) -> row_valid exactly 1 cycle after the 16th beat; row_data[32p+:32] = p for p = 0..63; row_index = 0.
2. NUM_PUS=6: beat0 {3,2,1,0}, beat1 {DEAD_0000, BEEF_0000, 5, 4} -> row PUs 0..5 = 0..5; both upper lanes discarded; completion after 2 beats.
3. Backpressure: row_ready=0, stream 2 rows then keep in_valid=1 -> in_ready drops after row 1's last beat. Raise row_ready -> rows 0 and 1 handshake in order with correct data. in_ready returns 1 the cycle after row 1 moves to the output register.
4. Full frame: 25 rows, in_last on the final beat -> frame_done pulses once after the handshake with row_index = 24; framing_error = 0; the next row has row_index = 0.
5. Early in_last on beat 3 of row 2 -> row emitted with row_index = 2, PUs 0..11 = data, PUs 12..63 = 0; framing_error = 1 and stays set; the next row has row_index = 0.
6. rst=1 for 1 cycle after 5 beats, then a clean 16-beat row -> no stale row emitted; the row matches the new data only; row_index = 0.
